audio_i2s_tx: RTL and testbench
===============================

// Module: audio_i2s_tx
// PURPOSE
// - Parametrised I2S master transmitter for the WM8731 DAC path; replaces the fixed-format vendor audio core.
// - Buffers stereo samples in a FIFO and generates BCLK/DACLRCK from the audio master clock (AUD_XCK domain).
// - Serialises samples onto DACDAT. Reports FIFO level and underruns to the HPS-facing register block.
// PARAMETERS
// - SAMPLE_W    16  bits per channel sample; legal range 8..SLOT_W.
// - SLOT_W      32  BCLK periods per channel slot; frame = 2*SLOT_W BCLK periods.
// - FIFO_DEPTH  16  stereo entries; must be a power of 2, >= 2.
// - BCLK_DIV    2   clk cycles per BCLK half-period; must be >= 1.
// PORTS
// - clk           in   1              audio master clock (12.288 MHz nominal).
// - reset_n       in   1              asynchronous, active-low reset.
// - en            in   1              1 = run the serial interface; 0 = idle.
// - s_data        in   2*SAMPLE_W     {left, right}, two's complement.
// - s_valid       in   1              sample write request.
// - s_ready       out  1              FIFO can accept; equals !full.
// - fifo_level    out  $clog2(D)+1    entries held, 0..FIFO_DEPTH.
// - underrun      out  1              sticky flag: a frame started with the FIFO empty.
// - underrun_cnt  out  16             underrun frames, saturating at 16'hFFFF.
// - underrun_clr  in   1              clears underrun and underrun_cnt.
// - aud_bclk      out  1              I2S bit clock to codec.
// - aud_daclrck   out  1              0 = left slot, 1 = right slot.
// - aud_dacdat    out  1              serial data, MSB first.
// BEHAVIOUR
// - Reset values: aud_bclk=0, aud_daclrck=0, aud_dacdat=0, s_ready=1, fifo_level=0, underrun=0, underrun_cnt=0.
// - All outputs are registered.
// - FIFO write:
//   - A push occurs when s_valid && s_ready.
//   - When full, s_valid is ignored, even if a pop happens in the same cycle.
//   - A simultaneous push and pop leaves fifo_level unchanged.
// - Clock divider:
//   - div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps and toggles aud_bclk.
//   - BCLK frequency = clk / (2*BCLK_DIV).
// - Bit counter and LRCK:
//   - bit_cnt counts 0..2*SLOT_W-1, advancing on each falling-edge toggle of aud_bclk (1->0), with wrap.
//   - aud_daclrck = (bit_cnt >= SLOT_W), updated on the same edge.
// - Frame load: on the falling edge where bit_cnt becomes 0, pop one FIFO entry into the hold register.
//   - If the FIFO is empty, load zeros, set underrun and increment underrun_cnt.
// - I2S data: on each falling edge, let j = bit_cnt mod SLOT_W.
//   - For j in 1..SAMPLE_W, aud_dacdat = sample[SAMPLE_W-j] of the current slot's channel.
//   - Otherwise aud_dacdat = 0. This gives the standard one-BCLK MSB delay after the LRCK edge.
// - underrun_clr: clears the flag and the counter.
//   - If it coincides with an underrun frame load, the load wins: underrun=1, underrun_cnt=1.
// - en=0 (including mid-frame):
//   - Next clk: div_cnt, bit_cnt, aud_bclk, aud_daclrck and aud_dacdat go to 0 and the hold register is cleared.
//   - The FIFO keeps accepting data and is not popped.
//   - On en 0->1, the first falling edge loads frame bit_cnt 0 and starts the left slot.
// - Reset mid-operation: the FIFO contents are discarded.
// CONFIGURATION
// - AUDIO_TX_VOLUME_EN defined: adds input atten [3:0].
//   - atten is sampled at frame load; both channels are loaded as sample >>> atten (arithmetic, sign-preserving).
//   - Underrun zeros stay zero.
// - AUDIO_TX_VOLUME_EN undefined: no atten port; samples are serialised unmodified.
// TESTING (SAMPLE_W=16, SLOT_W=32, FIFO_DEPTH=16, BCLK_DIV=2)
// - Reset: assert reset_n=0 asynchronously mid-clock.
//   -> all outputs at reset values immediately; s_ready=1, fifo_level=0.
// - Single frame: push {16'h8001, 16'h7FFE} with en=0, then en=1.
//   -> aud_bclk period 4 clk; LRCK low for 32 BCLKs, then high for 32.
//   -> left j=1..16 bits = 1,0x14,1; right bits = 0,1x14,0; all other bits 0.
// - Underrun: en=1 with an empty FIFO for 3 frames.
//   -> aud_dacdat stays 0; underrun=1, underrun_cnt=3.
//   -> pulse underrun_clr with the FIFO filled -> underrun=0, underrun_cnt=0.
// - Full: push 17 entries with en=0.
//   -> fifo_level=16, s_ready=0 after the 16th push; the 17th is dropped.
//   -> after en=1, the 16 frames match pushes 1..16 in order.
// - Mid-frame disable: drop en at bit_cnt=40.
//   -> next clk all serial outputs are 0 and fifo_level is unchanged.
//   -> re-enable: the next frame starts left with the next FIFO entry.
// - Volume (AUDIO_TX_VOLUME_EN): atten=4, push {16'h8000, 16'h0100}.
//   -> serialised left = 16'hF800, right = 16'h0010.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// FIFO-buffered I2S master transmitter generating BCLK/DACLRCK/DACDAT for a WM8731 DAC.
// Define AUDIO_TX_VOLUME_EN to add a 4-bit arithmetic attenuation applied at frame load.
module audio_i2s_tx #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BCLK_DIV   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [2*SAMPLE_W-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt,
    input  logic                          underrun_clr,
`ifdef AUDIO_TX_VOLUME_EN
    input  logic [3:0]                    atten,
`endif
    output logic                          aud_bclk,
    output logic                          aud_daclrck,
    output logic                          aud_dacdat
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BW = $clog2(2 * SLOT_W);

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  ready_q, ready_d;
    logic                  empty, push, pop;
    logic [2*SAMPLE_W-1:0] fifo_out, load_val;

    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d, j;
    logic                  run_q, run_d;
    logic                  bclk_q, bclk_d;
    logic                  lrck_q, lrck_d;
    logic                  dat_q, dat_d;
    logic                  load;
    logic [2*SAMPLE_W-1:0] hold_q, hold_d;
    logic [SAMPLE_W-1:0]   chan, mask;

    logic                  underrun_q, underrun_d;
    logic [15:0]           ucnt_q, ucnt_d;

    // FIFO bookkeeping; a full FIFO ignores s_valid even when a pop frees a slot.
    assign empty    = (level_q == '0);
    assign push     = s_valid && ready_q;
    assign pop      = load && !empty;
    assign fifo_out = mem[rptr_q];

    always_comb begin
        level_d = level_q + LW'(push) - LW'(pop);
        ready_d = (level_d != LW'(FIFO_DEPTH));
    end

`ifdef AUDIO_TX_VOLUME_EN
    logic signed [SAMPLE_W-1:0] left_att, right_att;
    always_comb begin
        left_att  = $signed(fifo_out[2*SAMPLE_W-1:SAMPLE_W]) >>> atten;
        right_att = $signed(fifo_out[SAMPLE_W-1:0]) >>> atten;
        load_val  = {left_att, right_att};
    end
`else
    assign load_val = fifo_out;
`endif

    // Serial engine: bit_cnt restarts at 0 on the first falling BCLK edge after enable.
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        run_d  = run_q;
        bclk_d = bclk_q;
        lrck_d = lrck_q;
        dat_d  = dat_q;
        hold_d = hold_q;
        load   = 1'b0;
        j      = '0;
        chan   = '0;
        mask   = '0;
        if (!en) begin
            div_d  = '0;
            bit_d  = '0;
            run_d  = 1'b0;
            bclk_d = 1'b0;
            lrck_d = 1'b0;
            dat_d  = 1'b0;
            hold_d = '0;
        end else begin
            if (div_q == DW'(BCLK_DIV - 1)) begin
                div_d  = '0;
                bclk_d = !bclk_q;
            end else begin
                div_d = div_q + DW'(1);
            end
            if ((div_q == DW'(BCLK_DIV - 1)) && bclk_q) begin
                if (!run_q || (bit_q == BW'(2 * SLOT_W - 1))) begin
                    bit_d = '0;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
                run_d  = 1'b1;
                load   = (bit_d == '0);
                lrck_d = (bit_d >= BW'(SLOT_W));
                j      = lrck_d ? (bit_d - BW'(SLOT_W)) : bit_d;
                chan   = lrck_d ? hold_q[SAMPLE_W-1:0] : hold_q[2*SAMPLE_W-1:SAMPLE_W];
                mask   = SAMPLE_W'(1) << (BW'(SAMPLE_W) - j);
                dat_d  = (j != '0) && (j <= BW'(SAMPLE_W)) && (|(chan & mask));
                if (load) begin
                    hold_d = empty ? '0 : load_val;
                end
            end
        end
    end

    // A simultaneous underrun load and clear leaves a fresh count of one.
    always_comb begin
        underrun_d = underrun_q;
        ucnt_d     = ucnt_q;
        if (load && empty) begin
            underrun_d = 1'b1;
            if (underrun_clr) begin
                ucnt_d = 16'd1;
            end else if (ucnt_q != 16'hFFFF) begin
                ucnt_d = ucnt_q + 16'd1;
            end
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
            ucnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            div_q      <= '0;
            bit_q      <= '0;
            run_q      <= 1'b0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            hold_q     <= '0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q    <= level_d;
            ready_q    <= ready_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            run_q      <= run_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            hold_q     <= hold_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign s_ready      = ready_q;
    assign fifo_level   = level_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
    assign aud_bclk     = bclk_q;
    assign aud_daclrck  = lrck_q;
    assign aud_dacdat   = dat_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: elapsed-time I2S model checked every cycle plus literal checks.
module tb_audio_i2s_tx;

    localparam int SW    = 16;
    localparam int SL    = 32;
    localparam int FD    = 16;
    localparam int BD    = 2;
    localparam int FRAME = 2 * SL * 2 * BD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        underrun_clr = 1'b0;
    logic        aud_bclk, aud_daclrck, aud_dacdat;
`ifdef AUDIO_TX_VOLUME_EN
    logic [3:0]  atten = 4'd0;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: n = enabled clk edges since en rose; frames are popped from q into hold.
    int          n = 0;
    logic [31:0] q[$];
    logic [31:0] hold = '0;
    logic        m_under = 1'b0;
    int          m_cnt = 0;

    logic [15:0] l_cap, r_cap;
    int          lr_bad, z_bad, per;

    audio_i2s_tx #(
        .SAMPLE_W  (SW),
        .SLOT_W    (SL),
        .FIFO_DEPTH(FD),
        .BCLK_DIV  (BD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt),
        .underrun_clr(underrun_clr),
`ifdef AUDIO_TX_VOLUME_EN
        .atten       (atten),
`endif
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] scale(input logic [31:0] d);
`ifdef AUDIO_TX_VOLUME_EN
        logic signed [15:0] l, r;
        l = $signed(d[31:16]) >>> atten;
        r = $signed(d[15:0]) >>> atten;
        return {l, r};
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] entry(input int i);
        logic [15:0] l, r;
        l = 16'h1000 + 16'(i) * 16'h0101;
        r = 16'h8000 | 16'(i << 4);
        return {l, r};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0;
            q.delete();
            hold = '0;
            m_under = 1'b0;
            m_cnt = 0;
        end else begin
            bit do_push, ld;
            do_push = s_valid && (q.size() < FD);
            ld = 1'b0;
            if (en) begin
                n++;
                if ((n % (2 * BD) == 0) && (((n / (2 * BD)) - 1) % (2 * SL) == 0)) ld = 1'b1;
            end else begin
                n = 0;
                hold = '0;
            end
            if (ld) begin
                if (q.size() > 0) begin
                    hold = scale(q.pop_front());
                end else begin
                    hold = '0;
                    m_under = 1'b1;
                    m_cnt = underrun_clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
                end
            end else if (underrun_clr) begin
                m_under = 1'b0;
                m_cnt = 0;
            end
            if (do_push) q.push_back(s_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && reset_n) begin
            int f, b, j;
            logic el, ed;
            logic [15:0] ch;
            f = n / (2 * BD);
            el = 1'b0;
            ed = 1'b0;
            if (f > 0) begin
                b = (f - 1) % (2 * SL);
                el = (b >= SL);
                j = b % SL;
                ch = el ? hold[15:0] : hold[31:16];
                if (j >= 1 && j <= SW) ed = ch[SW - j];
            end
            check("bclk", aud_bclk, 32'((n / BD) % 2));
            check("lrck", aud_daclrck, el);
            check("dacdat", aud_dacdat, ed);
            check("fifo_level", fifo_level, q.size());
            check("s_ready", s_ready, (q.size() < FD));
            check("underrun", underrun, m_under);
            check("underrun_cnt", underrun_cnt, m_cnt);
        end
    end

    task automatic push_word(input logic [31:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Records one frame from the DUT pins, starting at the first falling BCLK edge seen.
    task automatic capture(output logic [15:0] l, output logic [15:0] r, output int lrb,
                           output int zb, output int pr);
        int k, cyc, last;
        logic prev;
        k = 0; cyc = 0; last = 0; lrb = 0; zb = 0; pr = 0; l = '0; r = '0;
        prev = aud_bclk;
        while (k < 64 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev === 1'b1 && aud_bclk === 1'b0) begin
                if (k >= 1 && k <= 16) l[16 - k] = aud_dacdat;
                else if (k >= 33 && k <= 48) r[48 - k] = aud_dacdat;
                else if (aud_dacdat !== 1'b0) zb++;
                if (aud_daclrck !== (k >= 32)) lrb++;
                if (k == 1) pr = cyc - last;
                last = cyc;
                k++;
            end
            prev = aud_bclk;
        end
        check("capture_done", k, 64);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_bclk", aud_bclk, 0);
        check("rst_lrck", aud_daclrck, 0);
        check("rst_dat", aud_dacdat, 0);
        check("rst_ready", s_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_under", underrun, 0);
        check("rst_ucnt", underrun_cnt, 0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        push_word({16'h8001, 16'h7FFE});
        check("level_one", fifo_level, 1);
        @(negedge clk);
        en = 1'b1;
        capture(l_cap, r_cap, lr_bad, z_bad, per);
        check("single_left", l_cap, 16'h8001);
        check("single_right", r_cap, 16'h7FFE);
        check("single_lrck_pattern", lr_bad, 0);
        check("single_pad_zero", z_bad, 0);
        check("bclk_period", per, 4);
        @(negedge clk);
        en = 1'b0;

        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        en = 1'b1;
        repeat (600) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("underrun_flag", underrun, 1);
        check("underrun_cnt3", underrun_cnt, 3);
        push_word(32'h1234_5678);
        push_word(32'h0BAD_F00D);
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("clr_flag", underrun, 0);
        check("clr_cnt", underrun_cnt, 0);

        en = 1'b1;
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_bclk", aud_bclk, 0);
        check("arst_lrck", aud_daclrck, 0);
        check("arst_dat", aud_dacdat, 0);
        check("arst_ready", s_ready, 1);
        check("arst_level", fifo_level, 0);
        check("arst_under", underrun, 0);
        check("arst_ucnt", underrun_cnt, 0);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data = entry(i);
        end
        check("full_level16", fifo_level, 16);
        check("full_not_ready", s_ready, 0);
        @(negedge clk);
        s_valid = 1'b0;
        check("full_drop17", fifo_level, 16);

        @(negedge clk);
        en = 1'b1;
        repeat (932) @(negedge clk);
        check("mid_lrck_right", aud_daclrck, 1);
        check("mid_level_before", fifo_level, 12);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("dis_bclk", aud_bclk, 0);
        check("dis_lrck", aud_daclrck, 0);
        check("dis_dat", aud_dacdat, 0);
        check("dis_level", fifo_level, 12);
        @(negedge clk);
        en = 1'b1;
        capture(l_cap, r_cap, lr_bad, z_bad, per);
        check("resume_left", l_cap, 16'h1404);
        check("resume_right", r_cap, 16'h8040);
        check("resume_lrck_pattern", lr_bad, 0);
        repeat (11 * FRAME) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("drained_level", fifo_level, 0);
        check("drained_no_underrun", underrun, 0);

`ifdef AUDIO_TX_VOLUME_EN
        atten = 4'd4;
        push_word({16'h8000, 16'h0100});
        @(negedge clk);
        en = 1'b1;
        capture(l_cap, r_cap, lr_bad, z_bad, per);
        check("vol_left", l_cap, 16'hF800);
        check("vol_right", r_cap, 16'h0010);
        @(negedge clk);
        en = 1'b0;
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
